// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: FSM states, counter sizing and the MEM/WB bundle.
package mem_stage_pkg;

  localparam int MW_DATA_W   = 16;
  localparam int MW_REGSEL_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Width needed to count up to TIMEOUT without wrapping.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  typedef struct packed {
    logic                   valid;
    logic                   reg_write;
    logic                   mem_to_reg;
    logic                   halt;
    logic                   err;
    logic [MW_DATA_W-1:0]   mem_data;
    logic [MW_DATA_W-1:0]   alu_out;
    logic [MW_REGSEL_W-1:0] write_reg_sel;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register: synchronous reset, load enable, whole bundle at once.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_load,
  input  mem_wb_t i_d,
  output mem_wb_t o_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q <= '0;
    end else if (i_load) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: issues data-memory accesses, stalls upstream while one is in flight,
// and retires into the MEM/WB register. Handshake: mem_en is held with stable
// mem_wr/mem_addr/mem_wdata until the cycle mem_done is seen; mem_done with mem_en=0 is ignored.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W    = MW_DATA_W,
  parameter int REGSEL_W  = MW_REGSEL_W,
  parameter int TIMEOUT   = 64,
  parameter bit ALIGN_CHK = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_m,
  input  logic [DATA_W-1:0]   aluOut_m,
  input  logic [DATA_W-1:0]   read2Data_m,
  input  logic                memRead_m,
  input  logic                memWrite_m,
  input  logic                memToReg_m,
  input  logic                regWrite_m,
  input  logic                halt_m,
  input  logic [REGSEL_W-1:0] writeRegSel_m,
  output logic                mem_en,
  output logic                mem_wr,
  output logic [DATA_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_done,
  output logic                stall_m,
  output logic                valid_w,
  output logic                regWrite_w,
  output logic                memToReg_w,
  output logic                halt_w,
  output logic                err_w,
  output logic [DATA_W-1:0]   memData_w,
  output logic [DATA_W-1:0]   aluOut_w,
  output logic [REGSEL_W-1:0] writeRegSel_w,
  output state_t              dbg_state
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]   r_hold_addr, r_hold_wdata;
  logic                r_hold_wr, r_hold_mem_to_reg, r_hold_reg_write, r_hold_halt;
  logic [REGSEL_W-1:0] r_hold_sel;
  logic                w_hold_load, w_wb_load, w_memop, w_misalign;
  mem_wb_t             w_wb_d, w_wb_q;

  assign w_memop    = valid_m & (memRead_m | memWrite_m);
  assign w_misalign = ALIGN_CHK & aluOut_m[0];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_load = 1'b0;
    w_wb_load   = 1'b0;
    w_wb_d      = '0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    stall_m     = 1'b0;
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          w_wb_load = 1'b1;
          if (!w_memop) begin
            w_wb_d.valid         = valid_m;
            w_wb_d.reg_write     = regWrite_m;
            w_wb_d.mem_to_reg    = memToReg_m;
            w_wb_d.halt          = valid_m & halt_m;
            w_wb_d.alu_out       = aluOut_m;
            w_wb_d.write_reg_sel = writeRegSel_m;
            if (valid_m && halt_m) w_state_nxt = HALTED;
          end else if (w_misalign) begin
            w_wb_d.valid         = 1'b1;
            w_wb_d.mem_to_reg    = memToReg_m;
            w_wb_d.halt          = 1'b1;
            w_wb_d.err           = 1'b1;
            w_wb_d.alu_out       = aluOut_m;
            w_wb_d.write_reg_sel = writeRegSel_m;
            w_state_nxt          = HALTED;
          end else begin
            mem_en      = 1'b1;
            mem_wr      = memWrite_m;
            mem_addr    = aluOut_m;
            mem_wdata   = read2Data_m;
            w_hold_load = 1'b1;
            if (mem_done) begin
              w_wb_d.valid         = 1'b1;
              w_wb_d.reg_write     = regWrite_m & ~memWrite_m;
              w_wb_d.mem_to_reg    = memToReg_m;
              w_wb_d.halt          = halt_m;
              w_wb_d.mem_data      = memWrite_m ? '0 : mem_rdata;
              w_wb_d.alu_out       = aluOut_m;
              w_wb_d.write_reg_sel = writeRegSel_m;
              if (halt_m) w_state_nxt = HALTED;
            end else begin
              stall_m     = 1'b1;
              w_state_nxt = BUSY;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
        BUSY: begin
          // Upstream is frozen but not trusted: everything comes from the hold registers.
          mem_en    = 1'b1;
          mem_wr    = r_hold_wr;
          mem_addr  = r_hold_addr;
          mem_wdata = r_hold_wdata;
          stall_m   = ~mem_done;
          w_wb_load = 1'b1;
          if (mem_done) begin
            w_wb_d.valid         = 1'b1;
            w_wb_d.reg_write     = r_hold_reg_write & ~r_hold_wr;
            w_wb_d.mem_to_reg    = r_hold_mem_to_reg;
            w_wb_d.halt          = r_hold_halt;
            w_wb_d.mem_data      = r_hold_wr ? '0 : mem_rdata;
            w_wb_d.alu_out       = r_hold_addr;
            w_wb_d.write_reg_sel = r_hold_sel;
            w_state_nxt          = r_hold_halt ? HALTED : IDLE;
            w_cnt_nxt            = '0;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            w_wb_d.valid         = 1'b1;
            w_wb_d.mem_to_reg    = r_hold_mem_to_reg;
            w_wb_d.halt          = 1'b1;
            w_wb_d.err           = 1'b1;
            w_wb_d.alu_out       = r_hold_addr;
            w_wb_d.write_reg_sel = r_hold_sel;
            w_state_nxt          = HALTED;
            w_cnt_nxt            = '0;
          end else if (r_cnt != '1) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        HALTED: begin
          stall_m      = 1'b1;
          w_wb_load    = 1'b1;
          w_wb_d       = w_wb_q;
          w_wb_d.valid = 1'b0;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= IDLE;
      r_cnt             <= '0;
      r_hold_addr       <= '0;
      r_hold_wdata      <= '0;
      r_hold_wr         <= 1'b0;
      r_hold_mem_to_reg <= 1'b0;
      r_hold_reg_write  <= 1'b0;
      r_hold_halt       <= 1'b0;
      r_hold_sel        <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_hold_load) begin
        r_hold_addr       <= aluOut_m;
        r_hold_wdata      <= read2Data_m;
        r_hold_wr         <= memWrite_m;
        r_hold_mem_to_reg <= memToReg_m;
        r_hold_reg_write  <= regWrite_m;
        r_hold_halt       <= halt_m;
        r_hold_sel        <= writeRegSel_m;
      end
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_wb_load),
    .i_d    (w_wb_d),
    .o_q    (w_wb_q)
  );

  assign valid_w       = w_wb_q.valid;
  assign regWrite_w    = w_wb_q.reg_write;
  assign memToReg_w    = w_wb_q.mem_to_reg;
  assign halt_w        = w_wb_q.halt;
  assign err_w         = w_wb_q.err;
  assign memData_w     = w_wb_q.mem_data;
  assign aluOut_w      = w_wb_q.alu_out;
  assign writeRegSel_w = w_wb_q.write_reg_sel;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with TIMEOUT=4 and alignment checking enabled.
module tb_memory_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_m, memRead_m, memWrite_m, memToReg_m, regWrite_m, halt_m;
  logic [15:0] aluOut_m, read2Data_m, mem_rdata;
  logic [2:0]  writeRegSel_m;
  logic        mem_done;
  logic        mem_en, mem_wr, stall_m;
  logic [15:0] mem_addr, mem_wdata;
  logic        valid_w, regWrite_w, memToReg_w, halt_w, err_w;
  logic [15:0] memData_w, aluOut_w;
  logic [2:0]  writeRegSel_w;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  memory_stage #(.DATA_W(16), .REGSEL_W(3), .TIMEOUT(4), .ALIGN_CHK(1'b1)) dut (
    .clk(clk), .rst(rst), .valid_m(valid_m), .aluOut_m(aluOut_m),
    .read2Data_m(read2Data_m), .memRead_m(memRead_m), .memWrite_m(memWrite_m),
    .memToReg_m(memToReg_m), .regWrite_m(regWrite_m), .halt_m(halt_m),
    .writeRegSel_m(writeRegSel_m), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .stall_m(stall_m), .valid_w(valid_w),
    .regWrite_w(regWrite_w), .memToReg_w(memToReg_w), .halt_w(halt_w),
    .err_w(err_w), .memData_w(memData_w), .aluOut_w(aluOut_w),
    .writeRegSel_w(writeRegSel_w), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_m = 0; memRead_m = 0; memWrite_m = 0; memToReg_m = 0; regWrite_m = 0;
    halt_m = 0; aluOut_m = '0; read2Data_m = '0; writeRegSel_m = '0;
    mem_rdata = '0; mem_done = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  initial begin
    do_reset();
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_stall", 32'(stall_m), 0);
    check("rst_valid_w", 32'(valid_w), 0);
    check("rst_halt_err", 32'({halt_w, err_w}), 0);
    check("rst_alu_w", 32'(aluOut_w), 0);

    // ALU op retires one cycle later with no stall.
    valid_m = 1; aluOut_m = 16'h1234; regWrite_m = 1; writeRegSel_m = 3'd5;
    #1;
    check("alu_stall", 32'(stall_m), 0);
    check("alu_mem_en", 32'(mem_en), 0);
    tick();
    idle_inputs();
    check("alu_valid_w", 32'(valid_w), 1);
    check("alu_alu_w", 32'(aluOut_w), 32'h1234);
    check("alu_sel_w", 32'(writeRegSel_w), 5);
    check("alu_regwrite_w", 32'(regWrite_w), 1);
    check("alu_memdata_w", 32'(memData_w), 0);

    // Load completing in the issue cycle.
    valid_m = 1; memRead_m = 1; memToReg_m = 1; regWrite_m = 1; aluOut_m = 16'h0040;
    writeRegSel_m = 3'd2; mem_done = 1; mem_rdata = 16'hBEEF;
    #1;
    check("ld0_mem_en", 32'(mem_en), 1);
    check("ld0_addr", 32'(mem_addr), 32'h0040);
    check("ld0_wr", 32'(mem_wr), 0);
    check("ld0_stall", 32'(stall_m), 0);
    tick();
    idle_inputs();
    check("ld0_valid_w", 32'(valid_w), 1);
    check("ld0_memdata_w", 32'(memData_w), 32'hBEEF);
    check("ld0_memtoreg_w", 32'(memToReg_w), 1);
    check("ld0_regwrite_w", 32'(regWrite_w), 1);
    check("ld0_alu_w", 32'(aluOut_w), 32'h0040);
    #1;
    check("ld0_mem_en_drop", 32'(mem_en), 0);

    // Store with mem_done in the fourth cycle; upstream inputs go to garbage meanwhile.
    valid_m = 1; memWrite_m = 1; aluOut_m = 16'h0010; read2Data_m = 16'hA5A5;
    regWrite_m = 1; writeRegSel_m = 3'd3;
    #1;
    check("st_c0_en", 32'(mem_en), 1);
    check("st_c0_wr", 32'(mem_wr), 1);
    check("st_c0_addr", 32'(mem_addr), 32'h0010);
    check("st_c0_wdata", 32'(mem_wdata), 32'hA5A5);
    check("st_c0_stall", 32'(stall_m), 1);
    tick();
    memWrite_m = 0; memRead_m = 1; aluOut_m = 16'hFFFF; read2Data_m = 16'h1111;
    writeRegSel_m = 3'd6;
    #1;
    check("st_c1_state", 32'(dbg_state), 32'(BUSY));
    check("st_c1_addr", 32'(mem_addr), 32'h0010);
    check("st_c1_wdata", 32'(mem_wdata), 32'hA5A5);
    check("st_c1_wr", 32'(mem_wr), 1);
    check("st_c1_stall", 32'(stall_m), 1);
    check("st_c1_valid_w", 32'(valid_w), 0);
    tick();
    aluOut_m = 16'h7777; read2Data_m = 16'h2222;
    #1;
    check("st_c2_addr", 32'(mem_addr), 32'h0010);
    check("st_c2_wdata", 32'(mem_wdata), 32'hA5A5);
    check("st_c2_stall", 32'(stall_m), 1);
    check("st_c2_valid_w", 32'(valid_w), 0);
    tick();
    mem_done = 1;
    #1;
    check("st_c3_en", 32'(mem_en), 1);
    check("st_c3_stall", 32'(stall_m), 0);
    tick();
    idle_inputs();
    check("st_valid_w", 32'(valid_w), 1);
    check("st_regwrite_w", 32'(regWrite_w), 0);
    check("st_alu_w", 32'(aluOut_w), 32'h0010);
    check("st_sel_w", 32'(writeRegSel_w), 3);
    check("st_state", 32'(dbg_state), 32'(IDLE));

    // Misaligned load: no request, error retirement, then stuck in HALTED.
    valid_m = 1; memRead_m = 1; memToReg_m = 1; regWrite_m = 1; aluOut_m = 16'h0041;
    writeRegSel_m = 3'd1;
    #1;
    check("mis_mem_en", 32'(mem_en), 0);
    tick();
    idle_inputs();
    check("mis_valid_w", 32'(valid_w), 1);
    check("mis_err_halt", 32'({err_w, halt_w}), 32'b11);
    check("mis_regwrite_w", 32'(regWrite_w), 0);
    check("mis_state", 32'(dbg_state), 32'(HALTED));
    tick();
    check("mis_hold_valid_w", 32'(valid_w), 0);
    check("mis_hold_err_halt", 32'({err_w, halt_w}), 32'b11);
    check("mis_hold_stall", 32'(stall_m), 1);

    do_reset();
    check("rst2_state", 32'(dbg_state), 32'(IDLE));
    check("rst2_err_halt", 32'({err_w, halt_w}), 0);

    // Load that never completes: mem_en for 4 cycles then timeout error.
    valid_m = 1; memRead_m = 1; memToReg_m = 1; regWrite_m = 1; aluOut_m = 16'h0080;
    writeRegSel_m = 3'd4;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("to_c%0d_en", c), 32'(mem_en), 1);
      check($sformatf("to_c%0d_stall", c), 32'(stall_m), 1);
      tick();
    end
    check("to_state", 32'(dbg_state), 32'(HALTED));
    check("to_err_halt", 32'({err_w, halt_w}), 32'b11);
    check("to_valid_w", 32'(valid_w), 1);
    check("to_regwrite_w", 32'(regWrite_w), 0);
    check("to_mem_en", 32'(mem_en), 0);
    check("to_stall", 32'(stall_m), 1);
    mem_done = 1; mem_rdata = 16'h5555;
    tick();
    check("to_ignore_done_state", 32'(dbg_state), 32'(HALTED));
    check("to_ignore_done_en", 32'(mem_en), 0);
    check("to_ignore_done_valid", 32'(valid_w), 0);
    check("to_ignore_done_stall", 32'(stall_m), 1);

    do_reset();

    // Reset in the second BUSY cycle aborts the request without retirement.
    valid_m = 1; memRead_m = 1; memToReg_m = 1; regWrite_m = 1; aluOut_m = 16'h0020;
    writeRegSel_m = 3'd2;
    tick();
    tick();
    #1;
    check("rb_state_busy", 32'(dbg_state), 32'(BUSY));
    rst = 1;
    tick();
    rst = 0;
    idle_inputs();
    #1;
    check("rb_mem_en", 32'(mem_en), 0);
    check("rb_state", 32'(dbg_state), 32'(IDLE));
    check("rb_w_all", 32'({valid_w, regWrite_w, memToReg_w, halt_w, err_w}), 0);
    check("rb_w_data", 32'({memData_w, aluOut_w}), 0);
    valid_m = 1; aluOut_m = 16'h00C3; regWrite_m = 1; writeRegSel_m = 3'd7;
    tick();
    idle_inputs();
    check("rb_alu_valid_w", 32'(valid_w), 1);
    check("rb_alu_alu_w", 32'(aluOut_w), 32'h00C3);
    check("rb_alu_sel_w", 32'(writeRegSel_w), 7);

    // Halting ALU op retires and halts the stage.
    valid_m = 1; halt_m = 1; aluOut_m = 16'h0001;
    tick();
    idle_inputs();
    check("hlt_valid_w", 32'(valid_w), 1);
    check("hlt_halt_w", 32'(halt_w), 1);
    check("hlt_err_w", 32'(err_w), 0);
    check("hlt_state", 32'(dbg_state), 32'(HALTED));
    check("hlt_stall", 32'(stall_m), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 16-bit five-stage pipeline; sits directly downstream of the EX/MEM latch.
- Issues data-memory reads and writes over a request/done handshake that may take several cycles.
- Stalls upstream stages while an access is in flight, and retires each instruction into registered MEM/WB outputs.
- Handles halt retirement, memory timeout and misaligned-access errors.

Parameters:
- DATA_W, 16, datapath and address width.
- REGSEL_W, 3, destination-register select width.
- TIMEOUT, 64, max BUSY cycles without mem_done before error; legal range 2..255.
- ALIGN_CHK, 1, when 1 an odd address on a memory op is an error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_m  in  1  instruction in MEM is real (0 = bubble)
- aluOut_m  in  DATA_W  address / ALU result
- read2Data_m  in  DATA_W  store data
- memRead_m, memWrite_m, memToReg_m, regWrite_m, halt_m  in  1 each  control
- writeRegSel_m  in  REGSEL_W  destination register
- mem_en  out  1  memory request, held until done
- mem_wr  out  1  1 = write, 0 = read (valid with mem_en)
- mem_addr  out  DATA_W  access address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid with mem_done
- mem_done  in  1  access complete this cycle
- stall_m  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- valid_w, regWrite_w, memToReg_w, halt_w, err_w  out  1 each  MEM/WB control
- memData_w, aluOut_w  out  DATA_W  MEM/WB data
- writeRegSel_w  out  REGSEL_W  MEM/WB destination register

Behaviour:
- Reset: state=IDLE, counter=0, all *_w outputs 0, mem_en=0, stall_m=0.
- States: IDLE, BUSY, HALTED.
- memop = valid_m & (memRead_m | memWrite_m).
- IDLE, no memop:
  - On the next edge, W regs load the M inputs with valid_w=valid_m and memData_w=0.
  - Latency 1 cycle.
- IDLE, memop, aligned (or ALIGN_CHK=0):
  - mem_en=1 combinationally.
  - Same cycle: mem_addr=aluOut_m, mem_wdata=read2Data_m, mem_wr=memWrite_m.
  - Address, data and control are captured into internal hold registers.
  - If mem_done is also high that cycle: retire at the next edge, stall_m=0, stay IDLE.
  - Otherwise: stall_m=1, go to BUSY, counter=1.
- IDLE, memop, ALIGN_CHK=1 and aluOut_m[0]=1:
  - No request is issued.
  - Retire with err_w=1, halt_w=1, valid_w=1, regWrite_w=0; go to HALTED.
- BUSY:
  - mem_en=1; address, data and direction are driven from the hold registers (upstream is frozen but not trusted).
  - stall_m = ~mem_done.
  - W regs load valid_w=0 each stalled cycle (bubble into WB).
  - On mem_done: retire the held instruction and go to IDLE. For a read, memData_w=mem_rdata. stall_m=0 that cycle, so upstream advances on the same edge.
  - No mem_done and counter==TIMEOUT-1: drop mem_en, retire with err_w=1, halt_w=1, regWrite_w=0; go to HALTED.
  - Otherwise counter increments; the counter saturates and never wraps.
- Retire valid instruction with halt_m=1: W gets halt_w=1, valid_w=1; go to HALTED.
  - A halting mem op retires only after its access completes.
- HALTED:
  - stall_m=1, mem_en=0, valid_w=0.
  - halt_w and err_w hold their retired values.
  - Only rst exits HALTED.
- Stores retire with regWrite_w forced to 0. Loads keep regWrite_m.
- mem_done is ignored while mem_en=0.
- rst mid-BUSY: abort the request immediately (mem_en=0 in the cycle after the rst edge) and apply reset values; no retirement.

Decomposition:
- Package mem_stage_pkg holds:
  - the state enum {IDLE, BUSY, HALTED};
  - the counter width, computed as clog2(TIMEOUT+1);
  - a packed struct for the MEM/WB bundle (valid, regWrite, memToReg, halt, err, memData, aluOut, writeRegSel).
- One sub-module, mem_wb_reg: a synchronous-reset register for the struct with load enable. It instantiates once and can be reused by the WB forwarding logic.

Test Plan:
- ALU op, aluOut_m=0x1234, regWrite_m=1, sel=5 → next cycle valid_w=1, aluOut_w=0x1234, writeRegSel_w=5, stall_m never 1.
- Load at 0x0040 with mem_done in the same cycle, mem_rdata=0xBEEF → mem_en for one cycle, no stall, memData_w=0xBEEF, memToReg_w=1.
- Store 0xA5A5 to 0x0010, mem_done after 3 cycles:
  - stall_m=1 for exactly 3 cycles; mem_addr and mem_wdata stay stable while the inputs are changed to garbage;
  - valid_w=0 during the stall, then valid_w=1 with regWrite_w=0.
- Load with no mem_done, TIMEOUT=4 → mem_en high for 4 cycles, then err_w=1, halt_w=1, state HALTED, stall_m stuck at 1.
- Load at 0x0041 with ALIGN_CHK=1 → no mem_en, err_w=1, halt_w=1 next cycle.
- Assert rst during BUSY cycle 2 → mem_en=0 and all *_w=0 next cycle; a following ALU op retires normally.
